// File: rtl/dc_ipu_array_divider_pipe.sv
// -----------------------------------------------------------------------------
// dc_ipu_array_divider_pipe
// Fully pipelined unsigned restoring array divider. One operand pair can be
// accepted every cycle. Each pair then passes through WIDTH restoring steps
// before the result leaves the block. The pipeline is valid/ready handshaked,
// with a single global advance enable: the whole array either shifts by one
// bank or holds.
//
// Ports
//   clk          rising-edge clock
//   nreset       asynchronous, active-low reset
//   in_valid     dividend/divisor valid
//   in_ready     pair accepted this cycle (combinational from out_ready/out_valid)
//   dividend     unsigned dividend
//   divisor      unsigned divisor
//   out_valid    result valid (bank WIDTH)
//   out_ready    consumer accepts the result this cycle
//   quotient     unsigned quotient (all ones when divisor == 0)
//   remainder    unsigned remainder (equals dividend when divisor == 0)
//   div_by_zero  result belongs to a pair with divisor == 0
// -----------------------------------------------------------------------------
module dc_ipu_array_divider_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // Bank 0 holds the accepted operands. Bank k holds the state after k
    // restoring steps.
    logic             vld_q [0:WIDTH];
    logic [WIDTH-1:0] dsr_q [0:WIDTH];
    logic [WIDTH-1:0] rem_q [0:WIDTH];
    logic [WIDTH-1:0] dvd_q [0:WIDTH];   // unconsumed dividend bits, MSB first
    logic [WIDTH-1:0] quo_q [0:WIDTH];   // quotient bits shift in at the LSB
    logic             dbz_q [0:WIDTH];

    // Next-state values produced by each restoring step.
    logic [WIDTH-1:0] rem_d [1:WIDTH];
    logic [WIDTH-1:0] dvd_d [1:WIDTH];
    logic [WIDTH-1:0] quo_d [1:WIDTH];

    logic adv;

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    for (genvar k = 1; k <= WIDTH; k++) begin : g_step
        logic [WIDTH:0] t;
        logic           ge;

        assign t  = {rem_q[k-1], dvd_q[k-1][WIDTH-1]};
        assign ge = (t >= {1'b0, dsr_q[k-1]});
        // The compare is done at WIDTH+1 bits. When ge is set, t - divisor is
        // smaller than the divisor, so its low WIDTH bits equal the full
        // difference. That is why a WIDTH-bit subtraction is enough here.
        assign rem_d[k] = ge ? (t[WIDTH-1:0] - dsr_q[k-1]) : t[WIDTH-1:0];
        assign dvd_d[k] = {dvd_q[k-1][WIDTH-2:0], 1'b0};
        assign quo_d[k] = {quo_q[k-1][WIDTH-2:0], ge};
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i <= WIDTH; i++) begin
                vld_q[i] <= 1'b0;
                dsr_q[i] <= '0;
                rem_q[i] <= '0;
                dvd_q[i] <= '0;
                quo_q[i] <= '0;
                dbz_q[i] <= 1'b0;
            end
        end else if (adv) begin
            vld_q[0] <= in_valid;
            dsr_q[0] <= divisor;
            rem_q[0] <= '0;
            dvd_q[0] <= dividend;
            quo_q[0] <= '0;
            dbz_q[0] <= (divisor == '0);
            for (int i = 1; i <= WIDTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                dsr_q[i] <= dsr_q[i-1];
                rem_q[i] <= rem_d[i];
                dvd_q[i] <= dvd_d[i];
                quo_q[i] <= quo_d[i];
                dbz_q[i] <= dbz_q[i-1];
            end
        end
    end

    // Invalid slots carry junk internally, so the outputs are masked to 0.
    assign out_valid   = vld_q[WIDTH];
    assign quotient    = vld_q[WIDTH] ? quo_q[WIDTH] : '0;
    assign remainder   = vld_q[WIDTH] ? rem_q[WIDTH] : '0;
    assign div_by_zero = vld_q[WIDTH] & dbz_q[WIDTH];

endmodule

// File: tb/tb_dc_ipu_array_divider_pipe.sv
module tb_dc_ipu_array_divider_pipe;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         nreset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    dc_ipu_array_divider_pipe #(.WIDTH(W)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_pops  = 0;

    logic [2*W:0] exp_q[$];       // {dbz, quotient, remainder}
    logic         held_vld = 1'b0;
    logic [2*W+1:0] held;

    function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == 0) return {1'b1, {W{1'b1}}, a};
        return {1'b0, W'(a / b), W'(a % b)};
    endfunction

    // One clock: drive inputs, check outputs and in_ready, score results.
    // The task is entered and left just after a falling edge.
    task automatic cycle(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ordy, output logic acc);
        logic [2*W:0] e;
        in_valid = iv; dividend = a; divisor = b; out_ready = ordy;
        #1;
        n_tests++;
        if (in_ready !== (ordy | ~out_valid)) begin
            n_fail++;
            $display("FAIL in_ready: got %b want %b (out_valid=%b out_ready=%b)",
                     in_ready, ordy | ~out_valid, out_valid, ordy);
        end
        if (held_vld) begin
            n_tests++;
            if ({out_valid, div_by_zero, quotient, remainder} !== held) begin
                n_fail++;
                $display("FAIL stall_hold: got %h want %h",
                         {out_valid, div_by_zero, quotient, remainder}, held);
            end
        end
        if (out_valid !== 1'b1) begin
            n_tests++;
            if ({out_valid, div_by_zero, quotient, remainder} !== '0) begin
                n_fail++;
                $display("FAIL idle_zero: got v=%b q=%0d r=%0d dbz=%b want all 0",
                         out_valid, quotient, remainder, div_by_zero);
            end
        end else if (ordy) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: got q=%0d r=%0d with no pending op",
                         quotient, remainder);
            end else begin
                e = exp_q.pop_front();
                n_pops++;
                if ({div_by_zero, quotient, remainder} !== e) begin
                    n_fail++;
                    $display("FAIL result: got dbz=%b q=%0d r=%0d want dbz=%b q=%0d r=%0d",
                             div_by_zero, quotient, remainder, e[2*W], e[2*W-1:W], e[W-1:0]);
                end
            end
        end
        held_vld = (out_valid === 1'b1) && !ordy;
        held     = {out_valid, div_by_zero, quotient, remainder};
        acc      = iv && (in_ready === 1'b1);
        if (acc) exp_q.push_back(ref_div(a, b));
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        logic acc;
        int   guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin
            cycle(1'b0, '0, '0, 1'b1, acc);
            guard++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b0; dividend = '0; divisor = '0; out_ready = 1'b0;
        nreset = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({out_valid, quotient, remainder, div_by_zero} !== '0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b q=%0d r=%0d dbz=%b rdy=%b want 0/0/0/0/1",
                     out_valid, quotient, remainder, div_by_zero, in_ready);
        end
        nreset = 1'b1;
    endtask

    task automatic test_single(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] eq, input logic [W-1:0] er,
                               input logic edz);
        logic acc;
        int   acc_edge;
        int   guard = 0;
        cycle(1'b1, a, b, 1'b1, acc);
        acc_edge = cyc;
        while (out_valid !== 1'b1 && guard < 20) begin
            cycle(1'b0, '0, '0, 1'b1, acc);
            guard++;
        end
        n_tests++;
        if (cyc - acc_edge != W) begin
            n_fail++;
            $display("FAIL latency: got %0d edges want %0d", cyc - acc_edge, W);
        end
        n_tests++;
        if ({quotient, remainder, div_by_zero} !== {eq, er, edz}) begin
            n_fail++;
            $display("FAIL single %0d/%0d: got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b",
                     a, b, quotient, remainder, div_by_zero, eq, er, edz);
        end
        drain();
    endtask

    task automatic test_boundary();
        logic [W-1:0] ta [6] = '{8'd255, 8'd3,   8'd255, 8'd0, 8'd5,   8'd6};
        logic [W-1:0] tb [6] = '{8'd1,   8'd200, 8'd255, 8'd9, 8'd0,   8'd3};
        logic [W-1:0] tq [6] = '{8'd255, 8'd0,   8'd1,   8'd0, 8'd255, 8'd2};
        logic [W-1:0] tr [6] = '{8'd0,   8'd3,   8'd0,   8'd0, 8'd5,   8'd0};
        logic         tz [6] = '{1'b0,   1'b0,   1'b0,   1'b0, 1'b1,   1'b0};
        logic acc;
        int   guard = 0;
        for (int i = 0; i < 6; i++) cycle(1'b1, ta[i], tb[i], 1'b1, acc);
        while (out_valid !== 1'b1 && guard < 20) begin
            cycle(1'b0, '0, '0, 1'b1, acc);
            guard++;
        end
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || {quotient, remainder, div_by_zero} !== {tq[i], tr[i], tz[i]}) begin
                n_fail++;
                $display("FAIL boundary %0d/%0d: got v=%b q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b",
                         ta[i], tb[i], out_valid, quotient, remainder, div_by_zero, tq[i], tr[i], tz[i]);
            end
            cycle(1'b0, '0, '0, 1'b1, acc);
        end
        drain();
    endtask

    task automatic test_stream();
        logic         acc;
        logic [W-1:0] a, b;
        int           sent = 0;
        int           guard = 0;
        a = W'($urandom); b = W'($urandom);
        while (sent < 20 && guard < 400) begin
            cycle(1'b1, a, b, 1'($urandom_range(0, 1)), acc);
            if (acc) begin
                sent++;
                a = W'($urandom);
                b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            end
            guard++;
        end
        n_tests++;
        if (sent != 20) begin
            n_fail++;
            $display("FAIL stream_accept: got %0d accepted want 20", sent);
        end
        drain();
    endtask

    task automatic test_full_stall();
        logic acc;
        int   pops0;
        for (int i = 0; i < W + 1; i++) cycle(1'b1, W'($urandom), W'($urandom_range(1, 255)), 1'b1, acc);
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pipe: got out_valid=%b want 1", out_valid);
        end
        // Upstream keeps offering during the stall; none of it may be taken.
        for (int i = 0; i < 5; i++) cycle(1'b1, W'($urandom), W'($urandom), 1'b0, acc);
        n_tests++;
        if (exp_q.size() != W + 1) begin
            n_fail++;
            $display("FAIL stall_loss: got %0d pending want %0d", exp_q.size(), W + 1);
        end
        pops0 = n_pops;
        for (int i = 0; i < W + 1; i++) cycle(1'b0, '0, '0, 1'b1, acc);
        n_tests++;
        if (n_pops - pops0 != W + 1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_drain: got %0d results in %0d cycles (out_valid=%b) want %0d then idle",
                     n_pops - pops0, W + 1, out_valid, W + 1);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        logic acc;
        for (int i = 0; i < 4; i++) cycle(1'b1, W'($urandom), W'($urandom), 1'b1, acc);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, acc);
        nreset = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        exp_q.delete();
        held_vld = 1'b0;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        // Any result showing up now is flagged as unexpected by the scoreboard.
        for (int i = 0; i < 12; i++) cycle(1'b0, '0, '0, 1'b1, acc);
        test_single(8'd77, 8'd5, 8'd15, 8'd2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        test_boundary();
        test_stream();
        test_full_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dc_ipu_array_divider_pipe.md
DC_IPU_ARRAY_DIVIDER_PIPE -- requirements
Module: dc_ipu_array_divider_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand, quotient and remainder width in bits (WIDTH >= 2).
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 nreset  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  dividend/divisor valid.
REQ-005 in_ready  output  1  block accepts an operand pair this cycle.
REQ-006 dividend  input  WIDTH  unsigned dividend.
REQ-007 divisor  input  WIDTH  unsigned divisor.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  consumer accepts the result this cycle.
REQ-010 quotient  output  WIDTH  unsigned quotient.
REQ-011 remainder  output  WIDTH  unsigned remainder.
REQ-012 div_by_zero  output  1  the result belongs to an operand pair with divisor == 0.

Function
REQ-013 The block SHALL be a restoring array divider with WIDTH+1 register banks: bank 0 holds the accepted operands, and banks 1..WIDTH each hold the state after one restoring step.
REQ-014 Each bank SHALL hold: valid bit, divisor, partial remainder (WIDTH bits), unconsumed dividend bits, accumulated quotient bits, and the div_by_zero flag.
REQ-015 Step k (k = 1..WIDTH) SHALL form t = {partial remainder, next dividend bit, MSB first} as WIDTH+1 bits; if t >= divisor, the new remainder SHALL be t - divisor and the quotient bit 1, else the new remainder SHALL be t and the quotient bit 0.
REQ-016 The comparison and subtraction SHALL be unsigned at WIDTH+1 bits, so no overflow is possible; the stored remainder SHALL be the low WIDTH bits.
REQ-017 quotient, remainder, div_by_zero and out_valid SHALL be driven directly from bank WIDTH.
REQ-018 A global advance enable SHALL be defined: adv = out_ready OR NOT out_valid.
REQ-019 in_ready SHALL equal adv, and SHALL be combinational from out_ready and out_valid only, with no dependence on in_valid.
REQ-020 When adv = 1, all banks SHALL shift by one; bank 0 SHALL load valid = in_valid and capture the operands.
REQ-021 When adv = 0, all banks SHALL hold their contents, including valid bits.
REQ-022 An accepted pair (in_valid AND in_ready at edge n) SHALL reach bank WIDTH at edge n+WIDTH if adv stays 1; stalls SHALL extend this by exactly the number of adv = 0 cycles.
REQ-023 Throughput SHALL be one operation per cycle when out_ready is held at 1.
REQ-024 Bubbles (invalid slots) SHALL propagate and SHALL NOT be collapsed.
REQ-025 Results SHALL emerge in acceptance order, with no loss and no duplication.
REQ-026 A result SHALL be held stable (all outputs) while out_valid = 1 AND out_ready = 0.
REQ-027 For divisor == 0: div_by_zero SHALL be 1, quotient SHALL be all ones, and remainder SHALL equal the dividend. This follows naturally from REQ-015 and SHALL NOT be special-cased.
REQ-028 Registers of invalid slots SHALL be don't-care internally, but the outputs SHALL read 0 whenever out_valid = 0.
REQ-029 in_valid SHALL be ignored when in_ready = 0; the upstream block holds its data.

Reset
REQ-030 While nreset = 0, every bank's valid bit and data fields SHALL be 0.
REQ-031 While nreset = 0, out_valid, quotient, remainder and div_by_zero SHALL be 0, and in_ready SHALL be 1.
REQ-032 An assertion of reset mid-operation SHALL discard all in-flight operations, and no partial result SHALL appear afterwards.
REQ-033 On the first rising edge after nreset is released, the block SHALL accept input normally.

Verification (WIDTH=8)
REQ-034 Single operation: 100/7 accepted at edge n with out_ready = 1 -> out_valid at edge n+8, quotient = 14, remainder = 2, div_by_zero = 0.
REQ-035 Boundary operands: 255/1 -> 255 r 0; 3/200 -> 0 r 3; 255/255 -> 1 r 0; 0/9 -> 0 r 0.
REQ-036 Divide by zero: 5/0 -> quotient = 255, remainder = 5, div_by_zero = 1; the following operation 6/3 -> 2 r 0 with div_by_zero = 0.
REQ-037 Streaming with backpressure: 20 random back-to-back pairs while out_ready toggles pseudo-randomly -> all results are in order and match a reference model, outputs are stable during stalls, in_ready = 0 exactly when out_valid = 1 AND out_ready = 0.
REQ-038 Full stall: fill the pipeline, hold out_ready = 0 for 5 cycles -> nothing is lost; then release it -> 9 results drain at one per cycle.
REQ-039 Reset mid-flight: assert nreset 3 cycles after accepting 4 pairs -> out_valid = 0 immediately and stays 0 after release until a new pair has been accepted and 9 edges have passed.
